// File: rtl/async_dmux_rx_if.sv
// rtl/async_dmux_rx_if.sv - source/consumer bundle for the async capture FIFO
interface async_dmux_rx_if #(
   parameter int W     = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          val_async;
   logic [W-1:0]  d_async;
   logic          ready;
   logic          clr_ovf;
   logic          val_q;
   logic [W-1:0]  q;
   logic [CW-1:0] count;
   logic          overflow;

   modport master (
      output val_async, d_async, ready, clr_ovf,
      input  val_q, q, count, overflow
   );

   modport slave (
      input  val_async, d_async, ready, clr_ovf,
      output val_q, q, count, overflow
   );
endinterface

// File: rtl/async_dmux_rx.sv
// rtl/async_dmux_rx.sv - synchronised event capture of a foreign-domain word into a small FIFO
module async_dmux_rx #(
   parameter int  W           = 32,
   parameter int  SYNC_STAGES = 2,
   parameter int  DEPTH       = 4,
   parameter int  MODE        = 0,
   localparam int CW          = $clog2(DEPTH + 1)
) (
   input logic            clk,
   input logic            rst,
   async_dmux_rx_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;
   logic [W-1:0]           mem_q [DEPTH];
   logic [AW-1:0]          wptr_q, wptr_d;
   logic [AW-1:0]          rptr_q, rptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   s_last, ev, full, empty, push, pop, drop;

   // val_async enters at bit 0 and walks towards the last stage
   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.val_async};
   assign s_last = sync_q[SYNC_STAGES-1];

   // level protocol fires on a rise only; toggle protocol fires on every change
   assign ev = (MODE == 1) ? (s_last ^ prev_q) : (s_last & ~prev_q);

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = ~empty & bus.ready;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push  = ev & (~full | pop);
   assign drop  = ev & full & ~pop;

   // a drop in the same cycle as the clear keeps the flag set
   assign ovf_d = drop | (ovf_q & ~bus.clr_ovf);

   // pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   // synchroniser chain and edge-detect flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= s_last;
      end
   end

   // FIFO control state and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // storage: d_async is quasi-static at the write edge, so it is sampled directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wptr_q] <= bus.d_async;
      end
   end

   assign bus.val_q    = ~empty;
   assign bus.q        = mem_q[rptr_q];
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_async_dmux_rx.sv
// tb/tb_async_dmux_rx.sv - self-checking bench for async_dmux_rx across modes and sync depths
module tb_async_dmux_rx;
   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int ND    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic          val_a = 1'b0;
   logic [W-1:0]  d_a   = '0;
   logic          rdy   = 1'b0;
   logic          clr   = 1'b0;

   logic          vq  [ND];
   logic [W-1:0]  qv  [ND];
   logic [CW-1:0] cnt [ND];
   logic          ov  [ND];

   always #5 clk = ~clk;

   // dut 0: level SS2, dut 1: toggle SS2, dut 2: level SS3, dut 3: level SS4
   for (genvar g = 0; g < ND; g++) begin : g_dut
      async_dmux_rx_if #(.W(W), .DEPTH(DEPTH)) bus ();
      assign bus.val_async = val_a;
      assign bus.d_async   = d_a;
      assign bus.ready     = rdy;
      assign bus.clr_ovf   = clr;
      async_dmux_rx #(
         .W(W), .SYNC_STAGES((g < 2) ? 2 : g + 1), .DEPTH(DEPTH), .MODE((g == 1) ? 1 : 0)
      ) dut (
         .clk(clk), .rst(rst), .bus(bus)
      );
      assign vq[g]  = bus.val_q;
      assign qv[g]  = bus.q;
      assign cnt[g] = bus.count;
      assign ov[g]  = bus.overflow;
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   // reference: per-DUT queue of accepted words, overflow flag, and history of sampled val
   logic [W-1:0] mq [ND][$];
   logic         movf [ND];
   logic         vh [$];

   function automatic int ss_of(input int i);
      return (i < 2) ? 2 : i + 1;
   endfunction

   function automatic bit toggle_mode(input int i);
      return (i == 1);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < ND; i++) begin
         mq[i].delete();
         movf[i] = 1'b0;
      end
      vh.delete();
      for (int k = 0; k < 8; k++) vh.push_back(1'b0);
   endtask

   // an event is the val edge seen SS edges late; vh[0] is val at the previous edge
   task automatic model_edge();
      for (int i = 0; i < ND; i++) begin
         logic late, later, ev, pop, push;
         late  = vh[ss_of(i) - 1];
         later = vh[ss_of(i)];
         ev    = toggle_mode(i) ? (late != later) : (late && !later);
         pop   = (mq[i].size() > 0) && rdy;
         push  = ev && ((mq[i].size() < DEPTH) || pop);
         if (pop)  void'(mq[i].pop_front());
         if (push) mq[i].push_back(d_a);
         movf[i] = (ev && !push) || (movf[i] && !clr);
      end
      vh.push_front(val_a);
      void'(vh.pop_back());
   endtask

   task automatic compare_all();
      for (int i = 0; i < ND; i++) begin
         check($sformatf("d%0d val_q", i), 32'(vq[i]), 32'(mq[i].size() > 0));
         check($sformatf("d%0d count", i), 32'(cnt[i]), 32'(mq[i].size()));
         check($sformatf("d%0d overflow", i), 32'(ov[i]), 32'(movf[i]));
         if (mq[i].size() > 0) check($sformatf("d%0d q", i), qv[i], mq[i][0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic toggle_send(input logic [31:0] d, input int after);
      d_a = d;
      step();
      val_a = ~val_a;
      repeat (after) step();
   endtask

   typedef struct {
      logic        val;
      logic [31:0] d;
      logic        rdy;
      logic        exp_vq;
      int          exp_cnt;
      logic [31:0] exp_q;
      logic        chk_q;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                               input logic evq, input int ec, input logic [31:0] eq, input logic cq);
      vec_t t;
      t.val = v; t.d = d; t.rdy = r; t.exp_vq = evq; t.exp_cnt = ec; t.exp_q = eq; t.chk_q = cq;
      return t;
   endfunction

   initial begin
      vec_t tab [18];
      int   first [ND];
      int   gap;
      logic [31:0] exp_seq [4];

      // asynchronous reset at power-up
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < ND; i++) begin
         check($sformatf("rst d%0d val_q", i), 32'(vq[i]), 32'd0);
         check($sformatf("rst d%0d count", i), 32'(cnt[i]), 32'd0);
         check($sformatf("rst d%0d overflow", i), 32'(ov[i]), 32'd0);
         check($sformatf("rst d%0d q", i), qv[i], 32'd0);
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // level-mode latency on dut 0: one event per rise, popped the edge after it appears
      tab[0]  = mk(0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[1]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[2]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[3]  = mk(1, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1);
      tab[4]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[5]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[6]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[7]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[8]  = mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[9]  = mk(0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[10] = mk(0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[11] = mk(0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tab[12] = mk(0, 32'h12345678, 1, 0, 0, 0, 0);
      tab[13] = mk(1, 32'h12345678, 0, 0, 0, 0, 0);
      tab[14] = mk(1, 32'h12345678, 0, 0, 0, 0, 0);
      tab[15] = mk(1, 32'h12345678, 0, 1, 1, 32'h12345678, 1);
      tab[16] = mk(1, 32'h12345678, 0, 1, 1, 32'h12345678, 1);
      tab[17] = mk(1, 32'h12345678, 1, 0, 0, 0, 0);
      for (int k = 0; k < 18; k++) begin
         val_a = tab[k].val;
         d_a   = tab[k].d;
         rdy   = tab[k].rdy;
         step();
         check($sformatf("tab%0d val_q", k), 32'(vq[0]), 32'(tab[k].exp_vq));
         check($sformatf("tab%0d count", k), 32'(cnt[0]), 32'(tab[k].exp_cnt));
         if (tab[k].chk_q) check($sformatf("tab%0d q", k), qv[0], tab[k].exp_q);
      end
      rdy = 1'b0;

      // toggle mode back-to-back on dut 1, then drain in order
      for (int k = 1; k <= 4; k++) toggle_send(32'(k), 4);
      check("b2b count", 32'(cnt[1]), 32'd4);
      check("b2b val_q", 32'(vq[1]), 32'd1);
      rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("b2b pop%0d q", k), qv[1], 32'(k));
         step();
         check($sformatf("b2b pop%0d count", k), 32'(cnt[1]), 32'(4 - k));
      end
      rdy = 1'b0;

      // overflow: fifth event into a full FIFO is dropped
      for (int k = 1; k <= 5; k++) toggle_send(32'(k), 4);
      check("ovf count", 32'(cnt[1]), 32'd4);
      check("ovf flag", 32'(ov[1]), 32'd1);
      check("ovf head", qv[1], 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("ovf cleared", 32'(ov[1]), 32'd0);

      // full FIFO with a pop on the write edge accepts the new word
      d_a = 32'h9;
      step();
      val_a = ~val_a;
      step();
      step();
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      check("fullpp count", 32'(cnt[1]), 32'd4);
      check("fullpp overflow", 32'(ov[1]), 32'd0);
      exp_seq = '{32'h2, 32'h3, 32'h4, 32'h9};
      rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fullpp drain%0d", k), qv[1], exp_seq[k]);
         step();
      end
      rdy = 1'b0;
      check("fullpp empty", 32'(vq[1]), 32'd0);

      // reset mid-cycle with two entries queued
      toggle_send(32'h11, 4);
      toggle_send(32'h22, 4);
      check("pre-rst count", 32'(cnt[1]), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("midrst val_q", 32'(vq[1]), 32'd0);
      check("midrst count", 32'(cnt[1]), 32'd0);
      check("midrst overflow", 32'(ov[1]), 32'd0);
      check("midrst q", qv[1], 32'd0);
      val_a = 1'b0;
      step();
      rst = 1'b0;

      // synchroniser depth sweep on the level-mode DUTs
      repeat (3) step();
      d_a = 32'hA5A50003;
      step();
      val_a = 1'b1;
      for (int i = 0; i < ND; i++) first[i] = -1;
      for (int e = 1; e <= 8; e++) begin
         step();
         for (int i = 0; i < ND; i++) if (first[i] < 0 && vq[i]) first[i] = e;
      end
      check("sweep ss2 latency", 32'(first[0]), 32'd3);
      check("sweep ss3 latency", 32'(first[2]), 32'd4);
      check("sweep ss4 latency", 32'(first[3]), 32'd5);
      check("sweep ss3 data", qv[2], 32'hA5A50003);
      check("sweep ss4 data", qv[3], 32'hA5A50003);
      rdy = 1'b1;
      repeat (3) step();

      // randomized traffic against the reference queues
      gap = 6;
      for (int c = 0; c < 900; c++) begin
         if (((c / 150) % 2) == 1) rdy = ($urandom_range(0, 3) != 0);
         else rdy = ($urandom_range(0, 4) == 0);
         clr = ($urandom_range(0, 19) == 0);
         if (gap == 3) d_a = $urandom;
         if (gap == 0) begin
            val_a = ~val_a;
            gap = $urandom_range(5, 9);
         end else begin
            gap--;
         end
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
